// File: rtl/arbitro_rr_demux.sv
// Round-robin pop arbiter over four source FIFOs feeding a 4-way destination demux.
// Fixed two-cycle pop-to-push latency with a global hysteretic stall.
//
// state  | meaning
// IDLE   | all sources empty, nothing to pop
// ACTIVE | issuing round-robin pops
// PAUSED | a destination is almost full; wait for all to drain to almost empty
module arbitro_rr_demux #(
  parameter int BUS_SIZE  = 5,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           empty_in,
  input  logic [BUS_SIZE-1:0]  data_in0,
  input  logic [BUS_SIZE-1:0]  data_in1,
  input  logic [BUS_SIZE-1:0]  data_in2,
  input  logic [BUS_SIZE-1:0]  data_in3,
  input  logic [3:0]           valid_in,
  input  logic [3:0]           pause_dst,
  input  logic [3:0]           continua_dst,
  output logic [3:0]           pop_out,
  output logic [3:0]           push_out,
  output logic [BUS_SIZE-1:0]  data_out,
  output logic                 valid_out,
  output logic                 stalled,
  output logic [CNT_WIDTH-1:0] delivered
);

  typedef enum logic [1:0] {IDLE, ACTIVE, PAUSED} state_t;

  state_t              state;
  logic [1:0]          rr_ptr;
  logic [1:0]          grant;
  logic                grant_found;
  logic                pop_go;
  logic                cap_pending;
  logic [1:0]          cap_src;
  logic [BUS_SIZE-1:0] sel_data;
  logic                sel_valid;
  logic                any_src;
  logic                any_pause;

  assign any_src   = ~&empty_in;
  assign any_pause = |pause_dst;

  // Search from rr_ptr upward; iterating downward lets the closest candidate win.
  always_comb begin
    grant       = rr_ptr;
    grant_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (!empty_in[rr_ptr + 2'(k)]) begin
        grant       = rr_ptr + 2'(k);
        grant_found = 1'b1;
      end
    end
  end

  // The source's empty flag lags its pop, so a back-to-back pop of one source is skipped.
  assign pop_go  = (state == ACTIVE) && !any_pause && grant_found &&
                   !(cap_pending && (cap_src == grant));
  assign pop_out = pop_go ? (4'b0001 << grant) : 4'b0000;

  always_comb begin
    sel_data  = data_in0;
    sel_valid = valid_in[0];
    case (cap_src)
      2'd1: begin sel_data = data_in1; sel_valid = valid_in[1]; end
      2'd2: begin sel_data = data_in2; sel_valid = valid_in[2]; end
      2'd3: begin sel_data = data_in3; sel_valid = valid_in[3]; end
      default: ;
    endcase
  end

  assign stalled = (state == PAUSED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= 2'd0;
      cap_pending <= 1'b0;
      cap_src     <= 2'd0;
      push_out    <= 4'b0000;
      data_out    <= '0;
      valid_out   <= 1'b0;
      delivered   <= '0;
    end else begin
      if (any_pause) begin
        state <= PAUSED;
      end else begin
        case (state)
          IDLE:    if (any_src) state <= ACTIVE;
          ACTIVE:  if (!any_src) state <= IDLE;
          PAUSED:  if (&continua_dst) state <= any_src ? ACTIVE : IDLE;
          default: state <= IDLE;
        endcase
      end

      if (pop_go) begin
        rr_ptr  <= grant + 2'd1;
        cap_src <= grant;
      end
      cap_pending <= pop_go;

      // Words returned with valid low are dropped and never counted.
      if (cap_pending && sel_valid) begin
        push_out  <= 4'b0001 << sel_data[BUS_SIZE-1 -: 2];
        data_out  <= sel_data;
        valid_out <= 1'b1;
      end else begin
        push_out  <= 4'b0000;
        data_out  <= '0;
        valid_out <= 1'b0;
      end

      if (|push_out) delivered <= delivered + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_arbitro_rr_demux.sv
// Randomized bench for arbitro_rr_demux: a source-FIFO model, an abstract arbitration
// model that predicts pops and pushes, and a monitor that scores pushes from a queue.
module tb_arbitro_rr_demux;
  localparam int BW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    empty_in, valid_in, pause_dst, continua_dst;
  logic [BW-1:0] din [4];
  logic [3:0]    pop_out, push_out;
  logic [BW-1:0] data_out;
  logic          valid_out, stalled;
  logic [CW-1:0] delivered;

  arbitro_rr_demux #(.BUS_SIZE(BW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .empty_in(empty_in),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .valid_in(valid_in), .pause_dst(pause_dst), .continua_dst(continua_dst),
    .pop_out(pop_out), .push_out(push_out), .data_out(data_out),
    .valid_out(valid_out), .stalled(stalled), .delivered(delivered)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [3:0]    push;
    logic [BW-1:0] data;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            npush = 0;
  int            pause_hold = 0;
  exp_t          sb [$];
  logic [BW:0]   srcq [4][$];
  logic [3:0]    pop_seen = 4'b0000;
  int            mmode, mrr, mlast;
  logic [CW-1:0] exp_deliv;

  always @(posedge clk) cyc++;

  // Reference model: mode 0 idle, 1 active, 2 paused; predicts this cycle's pop.
  always @(negedge clk) begin : model
    int          g;
    logic [3:0]  ep;
    logic [BW:0] w;
    if (!reset) begin
      mmode = 0; mrr = 0; mlast = -1; pop_seen = 4'b0000;
      sb.delete();
    end else begin
      g = -1;
      if (mmode == 1 && pause_dst == 4'b0000)
        for (int k = 0; k < 4; k++)
          if (g < 0 && !empty_in[(mrr + k) % 4]) g = (mrr + k) % 4;
      if (g >= 0 && g == mlast) g = -1;
      ep = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      checks++;
      if (pop_out !== ep) begin
        errors++;
        $display("FAIL pop cyc=%0d got=%b exp=%b", cyc, pop_out, ep);
      end
      checks++;
      if (stalled !== (mmode == 2)) begin
        errors++;
        $display("FAIL stalled cyc=%0d got=%b exp=%b", cyc, stalled, (mmode == 2));
      end
      if (g >= 0) begin
        w = srcq[g][0];
        if (w[BW]) sb.push_back('{cyc + 2, 4'b0001 << w[BW-1:BW-2], w[BW-1:0]});
        mrr = (g + 1) % 4;
        mlast = g;
      end else begin
        mlast = -1;
      end
      if (pause_dst != 4'b0000) mmode = 2;
      else if (mmode == 0 && empty_in != 4'hF) mmode = 1;
      else if (mmode == 1 && empty_in == 4'hF) mmode = 0;
      else if (mmode == 2 && continua_dst == 4'hF) mmode = (empty_in != 4'hF) ? 1 : 0;
      pop_seen = pop_out;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      exp_deliv = '0;
    end else if (push_out != 4'b0000) begin
      checks++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        errors++;
        $display("FAIL unexpected_push cyc=%0d push=%b data=%b", cyc, push_out, data_out);
      end else begin
        e = sb.pop_front();
        if (push_out !== e.push || data_out !== e.data || valid_out !== 1'b1 || delivered !== exp_deliv) begin
          errors++;
          $display("FAIL push cyc=%0d got push=%b data=%b valid=%b deliv=%0d exp push=%b data=%b valid=1 deliv=%0d",
                   cyc, push_out, data_out, valid_out, delivered, e.push, e.data, exp_deliv);
        end
      end
      exp_deliv++;
      npush++;
    end else begin
      checks++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        errors++;
        $display("FAIL missing_push cyc=%0d got push=%b exp push=%b data=%b", cyc, push_out, sb[0].push, sb[0].data);
        void'(sb.pop_front());
      end else if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL valid_idle cyc=%0d got=%b exp=0", cyc, valid_out);
      end
    end
  end

  // Source FIFOs deliver the popped word the cycle after the pop; other cycles carry junk.
  task automatic step(input int rate, input bit allow_pause);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (pop_seen[i]) begin
        checks++;
        if (srcq[i].size() == 0) begin
          errors++;
          $display("FAIL underflow src=%0d got pop exp no pop", i);
        end else begin
          {valid_in[i], din[i]} = srcq[i].pop_front();
        end
      end else begin
        din[i] = BW'($urandom);
        valid_in[i] = 1'($urandom);
      end
      if (srcq[i].size() < 8 && $urandom_range(0, 3) < rate)
        srcq[i].push_back({1'($urandom_range(0, 7) != 0), BW'($urandom)});
      empty_in[i] = (srcq[i].size() == 0);
    end
    if (pause_hold > 0) begin
      pause_hold--;
    end else if (allow_pause && $urandom_range(0, 15) == 0) begin
      pause_dst = 4'($urandom_range(1, 15));
      pause_hold = $urandom_range(0, 3);
    end else begin
      pause_dst = 4'b0000;
    end
    continua_dst = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    empty_in = 4'hF; valid_in = 4'b0; pause_dst = 4'b0; continua_dst = 4'hF;
    for (int i = 0; i < 4; i++) din[i] = '0;

    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      empty_in = 4'($urandom); pause_dst = 4'($urandom); continua_dst = 4'($urandom);
      valid_in = 4'($urandom);
      for (int i = 0; i < 4; i++) din[i] = BW'($urandom);
      @(negedge clk);
      checks++;
      if ({pop_out, push_out, data_out, valid_out, stalled, delivered} !== '0) begin
        errors++;
        $display("FAIL reset_outputs pop=%b push=%b data=%b valid=%b stalled=%b deliv=%0d exp all 0",
                 pop_out, push_out, data_out, valid_out, stalled, delivered);
      end
    end
    @(posedge clk); #1;
    empty_in = 4'hF; pause_dst = 4'b0; continua_dst = 4'hF;
    reset = 1'b1;
    repeat (5) step(0, 0);

    for (int c = 0; c < 3000; c++) step(((c / 300) + 3) % 4, 1);
    pause_hold = 0;
    repeat (100) step(0, 0);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL flush pending=%0d exp 0", sb.size());
    end
    checks++;
    if (delivered !== CW'(npush)) begin
      errors++;
      $display("FAIL deliv_total got=%0d exp=%0d", delivered, CW'(npush));
    end
    checks++;
    if (npush < 256) begin
      errors++;
      $display("FAIL wrap_cover pushes=%0d exp >=256", npush);
    end

    repeat (6) step(3, 0);
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      step(3, 0);
      @(negedge clk);
      if (pop_out != 4'b0000) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pop_timeout got no pop exp pop within 50 cycles");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({pop_out, push_out, data_out, valid_out, stalled, delivered} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs pop=%b push=%b data=%b valid=%b stalled=%b deliv=%0d exp all 0",
               pop_out, push_out, data_out, valid_out, stalled, delivered);
    end
    for (int i = 0; i < 4; i++) srcq[i].delete();
    empty_in = 4'hF; pause_dst = 4'b0; continua_dst = 4'hF;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) step(0, 0);
    @(negedge clk);
    checks++;
    if (delivered !== '0 || push_out !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset deliv=%0d push=%b exp 0 and 0000", delivered, push_out);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
